// File: rtl/grant_xfer_pkg.sv
// grant_xfer_pkg: grant codes and FSM state encoding shared by the
// grant_xfer_unit top and its output holding register.
package grant_xfer_pkg;

  // Arbiter grant encodings (one bit per requester, A in the MSB).
  localparam logic [1:0] GNT_NONE    = 2'b00;
  localparam logic [1:0] GNT_A       = 2'b10;
  localparam logic [1:0] GNT_B       = 2'b01;
  localparam logic [1:0] GNT_ILLEGAL = 2'b11;

  // Ownership FSM states.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_OWN_A = 2'b01,
    ST_OWN_B = 2'b10,
    ST_DRAIN = 2'b11
  } xfer_state_t;

  // True when the grant names exactly the given owner code.
  function automatic logic grant_is(input logic [1:0] grant, input logic [1:0] owner);
    return (grant == owner);
  endfunction

endpackage

// File: rtl/grant_xfer_unit_out_reg.sv
// xfer_out_reg: one-entry data/valid/owner holding register feeding the
// shared bus. A load always wins over an accept in the same cycle, which
// is what makes back-to-back words flow at one per cycle.
module xfer_out_reg
  import grant_xfer_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              i_load,
  input  logic [DATA_W-1:0] i_load_data,
  input  logic [1:0]        i_load_owner,
  input  logic              i_accept,
  output logic              o_valid,
  output logic [DATA_W-1:0] o_data,
  output logic [1:0]        o_owner
);

  logic              r_valid;
  logic [DATA_W-1:0] r_data;
  logic [1:0]        r_owner;

  // Hold the current word until the sink takes it; refill on load.
  // NOTE: registers are written with <= so every flop samples pre-edge values.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_valid <= 1'b0;
      r_data  <= '0;
      r_owner <= GNT_NONE;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_data  <= i_load_data;
      r_owner <= i_load_owner;
    end else if (i_accept) begin
      // Word consumed with nothing behind it: the slot empties. The data
      // value is left in place; only valid and owner describe emptiness.
      r_valid <= 1'b0;
      r_owner <= GNT_NONE;
    end
  end

  assign o_valid = r_valid;
  assign o_data  = r_data;
  assign o_owner = r_owner;

endmodule

// File: rtl/grant_xfer_unit.sv
// grant_xfer_unit: routes the granted requester's words onto one shared
// bus through a one-entry output register, returns combinational acks and
// keeps wrapping per-requester accepted-word counts. Ownership tracks
// grant exactly; a word stuck on the bus when grant is withdrawn is
// drained before any new owner is served.
// Optional build macro: GRANT_XFER_ERR_EN adds a sticky err output that
// flags grant = 11 and direct 10 <-> 01 grant swaps.
module grant_xfer_unit #(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [1:0]        grant,
  input  logic              a_valid,
  input  logic [DATA_W-1:0] a_data,
  output logic              a_ack,
  input  logic              b_valid,
  input  logic [DATA_W-1:0] b_data,
  output logic              b_ack,
  input  logic              bus_ready,
  output logic              bus_valid,
  output logic [DATA_W-1:0] bus_data,
  output logic [1:0]        bus_owner,
  output logic [CNT_W-1:0]  a_count,
  output logic [CNT_W-1:0]  b_count
`ifdef GRANT_XFER_ERR_EN
  ,
  output logic              err
`endif
);

  import grant_xfer_pkg::*;

  xfer_state_t       r_state;
  xfer_state_t       w_state_next;
  logic              w_slot_free;
  logic              w_accept;
  logic              w_load;
  logic [DATA_W-1:0] w_load_data;
  logic [1:0]        w_load_owner;
  logic [CNT_W-1:0]  r_a_count;
  logic [CNT_W-1:0]  r_b_count;

  // The register can take a word if it is empty or being emptied this cycle.
  assign w_slot_free = !bus_valid || bus_ready;
  assign w_accept    = bus_valid && bus_ready;

  // State register for the ownership FSM.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_state_next;
  end

  // Next-state and ack decode; acks exist only while the owner keeps grant.
  always_comb begin
    // NOTE: every output gets a default first so no path can infer a latch.
    w_state_next = r_state;
    a_ack        = 1'b0;
    b_ack        = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (grant_is(grant, GNT_A))      w_state_next = ST_OWN_A;
        else if (grant_is(grant, GNT_B)) w_state_next = ST_OWN_B;
      end
      ST_OWN_A: begin
        if (grant_is(grant, GNT_A)) begin
          a_ack = a_valid && w_slot_free;
        end else begin
          // Grant withdrawn (00, 01 or 11): keep a stalled word until taken.
          w_state_next = (bus_valid && !bus_ready) ? ST_DRAIN : ST_IDLE;
        end
      end
      ST_OWN_B: begin
        if (grant_is(grant, GNT_B)) begin
          b_ack = b_valid && w_slot_free;
        end else begin
          w_state_next = (bus_valid && !bus_ready) ? ST_DRAIN : ST_IDLE;
        end
      end
      ST_DRAIN: begin
        // Grant is deliberately ignored until the held word leaves.
        if (w_accept) w_state_next = ST_IDLE;
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  // Only one ack can be high, so the source mux keys on a_ack alone.
  assign w_load       = a_ack || b_ack;
  assign w_load_data  = a_ack ? a_data : b_data;
  assign w_load_owner = a_ack ? GNT_A : GNT_B;

  xfer_out_reg #(
    .DATA_W (DATA_W)
  ) u_out_reg (
    .clock        (clock),
    .reset        (reset),
    .i_load       (w_load),
    .i_load_data  (w_load_data),
    .i_load_owner (w_load_owner),
    .i_accept     (w_accept),
    .o_valid      (bus_valid),
    .o_data       (bus_data),
    .o_owner      (bus_owner)
  );

  // Count each sink acceptance against the owner of the accepted word.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_a_count <= '0;
      r_b_count <= '0;
    end else if (w_accept) begin
      if (bus_owner == GNT_A) r_a_count <= r_a_count + CNT_W'(1);
      if (bus_owner == GNT_B) r_b_count <= r_b_count + CNT_W'(1);
    end
  end

  assign a_count = r_a_count;
  assign b_count = r_b_count;

`ifdef GRANT_XFER_ERR_EN
  logic [1:0] r_grant_prev;
  logic       r_err;

  // Sticky protocol error: illegal grant code or a swap with no 00 between.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_grant_prev <= GNT_NONE;
      r_err        <= 1'b0;
    end else begin
      r_grant_prev <= grant;
      if (grant == GNT_ILLEGAL ||
          (r_grant_prev == GNT_A && grant == GNT_B) ||
          (r_grant_prev == GNT_B && grant == GNT_A))
        r_err <= 1'b1;
    end
  end

  assign err = r_err;
`endif

endmodule

// File: tb/tb_grant_xfer_unit.sv
// Directed testbench for grant_xfer_unit. Inputs change 1 time unit after
// a rising edge; outputs are sampled 1 time unit later, well before the
// next edge. err checks are built only with GRANT_XFER_ERR_EN.
module tb_grant_xfer_unit;

  localparam int DATA_W = 8;
  localparam int CNT_W  = 8;

  logic              clock;
  logic              reset;
  logic [1:0]        grant;
  logic              a_valid;
  logic [DATA_W-1:0] a_data;
  logic              a_ack;
  logic              b_valid;
  logic [DATA_W-1:0] b_data;
  logic              b_ack;
  logic              bus_ready;
  logic              bus_valid;
  logic [DATA_W-1:0] bus_data;
  logic [1:0]        bus_owner;
  logic [CNT_W-1:0]  a_count;
  logic [CNT_W-1:0]  b_count;
`ifdef GRANT_XFER_ERR_EN
  logic              err;
`endif

  int n_pass;
  int n_total;

  grant_xfer_unit #(
    .DATA_W (DATA_W),
    .CNT_W  (CNT_W)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .grant     (grant),
    .a_valid   (a_valid),
    .a_data    (a_data),
    .a_ack     (a_ack),
    .b_valid   (b_valid),
    .b_data    (b_data),
    .b_ack     (b_ack),
    .bus_ready (bus_ready),
    .bus_valid (bus_valid),
    .bus_data  (bus_data),
    .bus_owner (bus_owner),
    .a_count   (a_count),
    .b_count   (b_count)
`ifdef GRANT_XFER_ERR_EN
    ,
    .err       (err)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Advance to 1 time unit after the next rising edge.
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; grant = 2'b00; a_valid = 1'b0; a_data = '0;
    b_valid = 1'b0; b_data = '0; bus_ready = 1'b0;
    #1;
    n_total++;
    if ({bus_valid, bus_data, bus_owner, a_count, b_count, a_ack, b_ack} !== '0)
      $display("FAIL reset_outputs: got v=%0b d=%h o=%b ac=%0d bc=%0d acks=%b%b, want all zero",
               bus_valid, bus_data, bus_owner, a_count, b_count, a_ack, b_ack);
    else n_pass++;
    #11 reset = 1'b0;           // release mid-cycle at t=12
    step();
    n_total++;
    if (bus_valid !== 1'b0 || a_ack !== 1'b0)
      $display("FAIL reset_idle: got v=%0b a_ack=%0b, want 0 0", bus_valid, a_ack);
    else n_pass++;
  endtask

  task automatic test_stream();
    logic [7:0] words [3];
    words[0] = 8'h11; words[1] = 8'h22; words[2] = 8'h33;
    grant = 2'b10; a_valid = 1'b1; a_data = words[0]; bus_ready = 1'b1;
    #1;
    n_total++;
    if (a_ack !== 1'b0) $display("FAIL stream_ack_idle: got %0b, want 0", a_ack);
    else n_pass++;
    step();                     // now OWN_A
    for (int i = 0; i < 3; i++) begin
      #1;
      n_total++;
      if (a_ack !== 1'b1 || b_ack !== 1'b0)
        $display("FAIL stream_ack[%0d]: got a=%0b b=%0b, want 1 0", i, a_ack, b_ack);
      else n_pass++;
      step();
      if (i < 2) a_data = words[i+1];
      else       a_valid = 1'b0;
      #1;
      n_total++;
      if (bus_valid !== 1'b1 || bus_data !== words[i] || bus_owner !== 2'b10)
        $display("FAIL stream_word[%0d]: got v=%0b d=%h o=%b, want 1 %h 10",
                 i, bus_valid, bus_data, bus_owner, words[i]);
      else n_pass++;
    end
    step();
    n_total++;
    if (bus_valid !== 1'b0 || a_count !== 8'd3 || b_count !== 8'd0)
      $display("FAIL stream_counts: got v=%0b a=%0d b=%0d, want 0 3 0", bus_valid, a_count, b_count);
    else n_pass++;
  endtask

  task automatic test_drain();
    // In OWN_A with an empty bus.
    bus_ready = 1'b0; a_valid = 1'b1; a_data = 8'h44;
    step();                     // 0x44 loaded
    grant = 2'b00; a_data = 8'h99;
    #1;
    n_total++;
    if (a_ack !== 1'b0) $display("FAIL drain_ack_drop: got %0b, want 0", a_ack);
    else n_pass++;
    step();                     // now DRAIN
    grant = 2'b10;              // must be ignored while draining
    for (int i = 0; i < 3; i++) begin
      #1;
      n_total++;
      if (bus_valid !== 1'b1 || bus_data !== 8'h44 || bus_owner !== 2'b10 || a_ack !== 1'b0)
        $display("FAIL drain_hold[%0d]: got v=%0b d=%h o=%b ack=%0b, want 1 44 10 0",
                 i, bus_valid, bus_data, bus_owner, a_ack);
      else n_pass++;
      step();
    end
    bus_ready = 1'b1;
    #1;
    n_total++;
    if (a_ack !== 1'b0) $display("FAIL drain_ack_accept: got %0b, want 0", a_ack);
    else n_pass++;
    step();                     // accepted, now IDLE
    #1;
    n_total++;
    if (a_count !== 8'd4 || bus_valid !== 1'b0 || a_ack !== 1'b0)
      $display("FAIL drain_done: got a=%0d v=%0b ack=%0b, want 4 0 0", a_count, bus_valid, a_ack);
    else n_pass++;
    grant = 2'b00; a_valid = 1'b0;
    step();
  endtask

  task automatic test_switch();
    grant = 2'b10;
    step();                     // OWN_A, bus empty
    grant = 2'b01; b_valid = 1'b1; b_data = 8'h5A; bus_ready = 1'b1;
    #1;
    n_total++;
    if (a_ack !== 1'b0 || b_ack !== 1'b0)
      $display("FAIL switch_cycle_ack: got a=%0b b=%0b, want 0 0", a_ack, b_ack);
    else n_pass++;
    step();                     // IDLE
    n_total++;
    if (b_ack !== 1'b0) $display("FAIL switch_idle_ack: got %0b, want 0", b_ack);
    else n_pass++;
    step();                     // OWN_B
    n_total++;
    if (b_ack !== 1'b1) $display("FAIL switch_b_ack: got %0b, want 1", b_ack);
    else n_pass++;
    step();
    b_valid = 1'b0;
    #1;
    n_total++;
    if (bus_valid !== 1'b1 || bus_data !== 8'h5A || bus_owner !== 2'b01)
      $display("FAIL switch_word: got v=%0b d=%h o=%b, want 1 5a 01", bus_valid, bus_data, bus_owner);
    else n_pass++;
`ifdef GRANT_XFER_ERR_EN
    n_total++;
    if (err !== 1'b1) $display("FAIL switch_err: got %0b, want 1", err);
    else n_pass++;
`endif
    step();
    n_total++;
    if (b_count !== 8'd1 || a_count !== 8'd4)
      $display("FAIL switch_counts: got a=%0d b=%0d, want 4 1", a_count, b_count);
    else n_pass++;
  endtask

  task automatic test_wrap();
    // OWN_B, b_count = 1: stream 254 words to reach 0xFF.
    bus_ready = 1'b1;
    for (int i = 0; i < 254; i++) begin
      b_valid = 1'b1; b_data = 8'(i);
      step();
    end
    b_valid = 1'b0;
    step();
    n_total++;
    if (b_count !== 8'hFF || a_count !== 8'd4)
      $display("FAIL wrap_pre: got a=%0d b=%h, want 4 ff", a_count, b_count);
    else n_pass++;
    b_valid = 1'b1; b_data = 8'hC3;
    step();
    b_valid = 1'b0;
    step();
    n_total++;
    if (b_count !== 8'h00 || a_count !== 8'd4)
      $display("FAIL wrap_post: got a=%0d b=%h, want 4 00", a_count, b_count);
    else n_pass++;
  endtask

  task automatic test_illegal();
    grant = 2'b00;
    step();                     // IDLE
    grant = 2'b11; a_valid = 1'b1; b_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_total++;
      if (a_ack !== 1'b0 || b_ack !== 1'b0 || bus_valid !== 1'b0)
        $display("FAIL illegal_quiet[%0d]: got a=%0b b=%0b v=%0b, want 0 0 0", i, a_ack, b_ack, bus_valid);
      else n_pass++;
      step();
`ifdef GRANT_XFER_ERR_EN
      n_total++;
      if (err !== 1'b1) $display("FAIL illegal_err[%0d]: got %0b, want 1", i, err);
      else n_pass++;
`endif
    end
    grant = 2'b00; a_valid = 1'b0; b_valid = 1'b0;
    step();
`ifdef GRANT_XFER_ERR_EN
    n_total++;
    if (err !== 1'b1) $display("FAIL illegal_sticky: got %0b, want 1", err);
    else n_pass++;
`endif
  endtask

  task automatic test_reset_mid();
    grant = 2'b10; a_valid = 1'b1; a_data = 8'h77; bus_ready = 1'b0;
    step();                     // OWN_A
    step();                     // 0x77 held, bus_ready low
    n_total++;
    if (bus_valid !== 1'b1 || bus_data !== 8'h77)
      $display("FAIL rstmid_pre: got v=%0b d=%h, want 1 77", bus_valid, bus_data);
    else n_pass++;
    #2 reset = 1'b1;            // mid-cycle, no clock edge nearby
    #1;
    n_total++;
    if (bus_valid !== 1'b0 || bus_owner !== 2'b00 || bus_data !== 8'h00 ||
        a_count !== 8'd0 || b_count !== 8'd0)
      $display("FAIL rstmid_async: got v=%0b o=%b d=%h a=%0d b=%0d, want all zero",
               bus_valid, bus_owner, bus_data, a_count, b_count);
    else n_pass++;
`ifdef GRANT_XFER_ERR_EN
    n_total++;
    if (err !== 1'b0) $display("FAIL rstmid_err: got %0b, want 0", err);
    else n_pass++;
`endif
    #1 reset = 1'b0;
    #1;
    n_total++;
    if (a_ack !== 1'b0) $display("FAIL rstmid_idle_ack: got %0b, want 0", a_ack);
    else n_pass++;
    step();                     // IDLE -> OWN_A
    n_total++;
    if (a_ack !== 1'b1) $display("FAIL rstmid_own_ack: got %0b, want 1", a_ack);
    else n_pass++;
  endtask

  initial begin
    n_pass  = 0;
    n_total = 0;
    test_reset();
    test_stream();
    test_drain();
    test_switch();
    test_wrap();
    test_illegal();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  // Hard time limit so the bench always terminates.
  initial begin
    #100000;
    $display("FAIL timeout: simulation exceeded time limit, got %0d/%0d", n_pass, n_total);
    $fatal(1);
  end

endmodule

// File: doc/grant_xfer_unit.md
Name: grant_xfer_unit

Overview:
Downstream consumer of the two-requester arbiter's grant[1:0]. It routes the granted requester's data words onto a single shared output bus through a one-entry output register, with ready/valid flow control. It returns per-requester acknowledges and keeps running per-requester transfer counts. Ownership follows grant exactly, with no data loss when grant is withdrawn mid-transfer.

Parameters:
DATA_W, 8, width of requester and bus data words
CNT_W, 8, width of per-requester accepted-word counters (wrapping)

Ports:
clock  input  1  system clock, all state updates on posedge
reset  input  1  asynchronous, active-high; clears all state immediately
grant  input  2  from arbiter: 10 = A owns, 01 = B owns, 00 = none, 11 = illegal
a_valid  input  1  requester A has a word on a_data
a_data  input  DATA_W  requester A word
a_ack  output  1  combinational; A's word is taken this cycle
b_valid  input  1  requester B has a word on b_data
b_data  input  DATA_W  requester B word
b_ack  output  1  combinational; B's word is taken this cycle
bus_ready  input  1  shared sink can accept bus_data this cycle
bus_valid  output  1  registered; bus_data holds a valid word
bus_data  output  DATA_W  registered shared-bus word
bus_owner  output  2  registered; source of the word in bus_data (10 = A, 01 = B, 00 = none)
a_count  output  CNT_W  number of A words accepted by the sink
b_count  output  CNT_W  number of B words accepted by the sink

Behaviour:
- Reset values: state = IDLE, bus_valid = 0, bus_data = 0, bus_owner = 00, a_count = 0, b_count = 0. Acks are 0 in IDLE.
- FSM states: IDLE, OWN_A, OWN_B, DRAIN.
- IDLE:
  - grant = 10 -> OWN_A next cycle.
  - grant = 01 -> OWN_B next cycle.
  - grant = 00 or 11 -> stay in IDLE.
  - No words are loaded in IDLE.
- OWN_A, while grant = 10:
  - a_ack = a_valid & (!bus_valid | bus_ready).
  - On a_ack, the output register loads a_data and sets bus_valid = 1, bus_owner = 10; the word appears on the next cycle (1-cycle latency).
  - OWN_B is symmetric with grant = 01, b_*, and owner code 01.
  - Ack is never asserted for the non-owner.
- Sink acceptance: bus_valid & bus_ready. If no new load happens the same cycle, bus_valid clears next cycle. Accept and load in the same cycle gives back-to-back words at one word per cycle.
- Counters: on each acceptance, increment the counter selected by bus_owner (mod 2^CNT_W; 0xFF wraps to 0x00).
- Grant leaves the owner code while in OWN_x:
  - No ack in that cycle.
  - If bus_valid & !bus_ready -> DRAIN. Otherwise -> IDLE, with any word accepted in that cycle still counted.
- DRAIN:
  - Holds bus_data and bus_owner; no acks.
  - On acceptance -> IDLE, and the counter increments.
  - Grant is ignored until IDLE is reached.
- A direct grant change 10 -> 01 always passes through IDLE (and DRAIN if needed). B's first ack therefore comes at least 2 cycles after the grant change.
- grant = 11 while in OWN_x is treated as "grant left the owner".
- Reset mid-operation: any held word is discarded, counters clear, and the FSM returns to IDLE asynchronously.

Optional Feature:
GRANT_XFER_ERR_EN
- Defined:
  - Adds output err (1 bit, reset 0, sticky until reset).
  - err sets on the cycle after grant = 11 is sampled in any state.
  - err also sets on a direct 10 <-> 01 grant change without an intervening 00.
- Undefined: port err is absent and the checks are not built; all other behaviour is identical.

Decomposition:
- Shared package grant_xfer_pkg holds:
  - grant codes GNT_NONE = 2'b00, GNT_A = 2'b10, GNT_B = 2'b01, GNT_ILLEGAL = 2'b11.
  - The FSM state enum.
- One natural sub-module: xfer_out_reg, a one-entry data/valid/owner holding register with load and accept inputs. The FSM, ack logic and counters stay in the top module.

Test Plan:
- Reset asserted mid-cycle with bus_valid = 1 -> bus_valid, counts and owner go to 0 immediately, without waiting for a clock edge; state is IDLE after reset release.
- grant = 10, a_valid = 1, a_data = 0x11, 0x22, 0x33 on consecutive cycles, bus_ready = 1 -> a_ack high starting the cycle after grant; bus_data 0x11/0x22/0x33 on consecutive cycles with bus_owner = 10; a_count = 3, b_count = 0.
- OWN_A holding 0x44 with bus_ready = 0, grant drops to 00 -> DRAIN; 0x44 held for 3 cycles; bus_ready = 1 -> accepted, a_count increments, then IDLE; no a_ack during DRAIN.
- grant 10 -> 01 directly with an empty bus, b_valid = 1, b_data = 0x5A -> no ack on the switch cycle; b_ack at least 2 cycles later; bus_data = 0x5A with bus_owner = 01; with GRANT_XFER_ERR_EN, err = 1.
- b_count at 0xFF, one more B word accepted -> b_count = 0x00; a_count unchanged.
- grant = 11 in IDLE with a_valid = b_valid = 1 -> no acks, bus_valid stays 0; with GRANT_XFER_ERR_EN, err = 1 the next cycle and stays 1 until reset.
